uart_tx_fifo: RTL and testbench

Byte FIFO between the CPU data bus and the `uart_tx` serializer, so software can queue a burst of characters without polling per byte. The CPU writes bytes into a `2**DEPTH_LOG2` entry buffer. A drain state machine pops one byte at a time and issues it on `uart_tx`'s bus-slave port. It waits for `uart_tx` to report idle before issuing the next byte.

---
 rtl/uart_tx_fifo_pkg.sv | 31 +++
 rtl/uart_tx_fifo_fifo_sync.sv | 66 ++++++
 rtl/uart_tx_fifo.sv | 131 +++++++++++++
 tb/tb_uart_tx_fifo.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_fifo_pkg.sv
// Constants shared between uart_tx_fifo and the uart_tx serializer:
// status bit positions, drain FSM encodings and the busy-guard length.
package uart_tx_fifo_pkg;

    localparam int STAT_ACTIVE = 0;
    localparam int STAT_FULL   = 1;
    localparam int STAT_EMPTY  = 2;
    localparam int STAT_OVF    = 3;

    typedef enum logic [1:0] {
        DRAIN_IDLE  = 2'd0,
        DRAIN_ISSUE = 2'd1,
        DRAIN_GUARD = 2'd2,
        DRAIN_WAIT  = 2'd3
    } drainState_e;

    localparam int GUARD_W = 2;
    localparam logic [GUARD_W-1:0] TX_GUARD_CYCLES = 2'd2;

    function automatic logic [7:0] packStatus(input logic ovf, input logic empty,
                                              input logic full, input logic active);
        logic [7:0] s;
        s = '0;
        s[STAT_OVF]    = ovf;
        s[STAT_EMPTY]  = empty;
        s[STAT_FULL]   = full;
        s[STAT_ACTIVE] = active;
        return s;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_fifo_sync.sv
// Generic synchronous FIFO with registered storage; pushes while full and
// pops while empty are ignored. Read data is the current head entry.
import uart_tx_fifo_pkg::*;

module fifo_sync #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_push,
    input  logic [WIDTH-1:0]      i_wdata,
    input  logic                  i_pop,
    output logic [WIDTH-1:0]      o_rdata,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [DEPTH_LOG2:0]   o_count
);

    localparam logic [DEPTH_LOG2:0]   FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE    = (DEPTH_LOG2+1)'(1);

    logic [WIDTH-1:0]      mem_q [0:(1<<DEPTH_LOG2)-1];
    logic [DEPTH_LOG2-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  doPush, doPop;

    assign o_full  = (count_q == FULL_COUNT);
    assign o_empty = (count_q == '0);
    assign o_count = count_q;
    assign o_rdata = mem_q[rd_q];
    assign doPush  = i_push & ~o_full;
    assign doPop   = i_pop & ~o_empty;

    always_comb begin
        rd_d    = rd_q;
        wr_d    = wr_q;
        count_d = count_q;
        if (doPush) wr_d = wr_q + PTR_ONE;
        if (doPop)  rd_d = rd_q + PTR_ONE;
        case ({doPush, doPop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: entries are only read once the count covers them.
    always_ff @(posedge i_clk) begin
        if (doPush) mem_q[wr_q] <= i_wdata;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte queue in front of uart_tx: CPU pushes bytes, a drain FSM feeds them one
// at a time to the serializer. Define UART_TX_FIFO_OVF_EN for a sticky overflow flag.
import uart_tx_fifo_pkg::*;

module uart_tx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_cyc,
    input  logic       i_we,
    input  logic [7:0] i_dat,
    output logic [7:0] o_dat,
    output logic       o_tx_cyc,
    output logic       o_tx_we,
    output logic [7:0] o_tx_dat,
    input  logic [7:0] i_tx_stat,
    output logic       o_int
);

    localparam logic [GUARD_W-1:0] GUARD_LAST = GUARD_W'(1);

    logic                push, pop, fifoFull, fifoEmpty, active, ovf;
    logic [7:0]          fifoRdata;
    logic [DEPTH_LOG2:0] fifoCount;
    logic                unusedBits;

    drainState_e         state_q, state_d;
    logic                txStb_q, txStb_d;
    logic [7:0]          txDat_q, txDat_d;
    logic [GUARD_W-1:0]  guard_q, guard_d;
    logic                int_q, int_d;

    assign push       = i_cyc & i_we;
    assign unusedBits = ^{i_tx_stat[7:1], fifoCount};

    fifo_sync #(
        .WIDTH      (8),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) uFifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (push),
        .i_wdata (i_dat),
        .i_pop   (pop),
        .o_rdata (fifoRdata),
        .o_full  (fifoFull),
        .o_empty (fifoEmpty),
        .o_count (fifoCount)
    );

    // The guard hides the serializer's busy flag until it has had time to rise.
    always_comb begin
        state_d = state_q;
        txStb_d = txStb_q;
        txDat_d = txDat_q;
        guard_d = guard_q;
        int_d   = 1'b0;
        pop     = 1'b0;
        case (state_q)
            DRAIN_IDLE: begin
                if (!fifoEmpty) begin
                    pop     = 1'b1;
                    txDat_d = fifoRdata;
                    txStb_d = 1'b1;
                    state_d = DRAIN_ISSUE;
                end
            end
            DRAIN_ISSUE: begin
                txStb_d = 1'b0;
                guard_d = TX_GUARD_CYCLES;
                state_d = DRAIN_GUARD;
            end
            DRAIN_GUARD: begin
                guard_d = guard_q - GUARD_LAST;
                if (guard_q == GUARD_LAST) state_d = DRAIN_WAIT;
            end
            DRAIN_WAIT: begin
                if (!i_tx_stat[0]) begin
                    state_d = DRAIN_IDLE;
                    int_d   = fifoEmpty;
                end
            end
            default: state_d = DRAIN_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= DRAIN_IDLE;
            txStb_q <= 1'b0;
            txDat_q <= '0;
            guard_q <= '0;
            int_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            txStb_q <= txStb_d;
            txDat_q <= txDat_d;
            guard_q <= guard_d;
            int_q   <= int_d;
        end
    end

`ifdef UART_TX_FIFO_OVF_EN
    logic ovf_q, ovf_d;

    // A dropped push outranks a status read clearing the flag.
    always_comb begin
        ovf_d = ovf_q;
        if (i_cyc & ~i_we)           ovf_d = 1'b0;
        if (i_cyc & i_we & fifoFull) ovf_d = 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) ovf_q <= 1'b0;
        else         ovf_q <= ovf_d;
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    assign active   = ~fifoEmpty | (state_q != DRAIN_IDLE);
    assign o_dat    = packStatus(ovf, fifoEmpty, fifoFull, active);
    assign o_tx_cyc = txStb_q;
    assign o_tx_we  = txStb_q;
    assign o_tx_dat = txDat_q;
    assign o_int    = int_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a shortened uart_tx busy model that
// logs every issued byte and flags strobes issued while a frame is in flight.
module tb_uart_tx_fifo;

    localparam int BUSY_LEN = 10;
`ifdef UART_TX_FIFO_OVF_EN
    localparam logic [7:0] FULL_OVF_STAT = 8'h0B;
`else
    localparam logic [7:0] FULL_OVF_STAT = 8'h03;
`endif

    logic       clk = 1'b0;
    logic       iReset, iCyc, iWe, holdBusy;
    logic [7:0] iDat, oDat, oTxDat, txStat;
    logic       oTxCyc, oTxWe, oInt;

    int assertCount = 0;
    int failCount   = 0;

    int uartCnt = 0, cycleNo = 0, strobeCount = 0, intCount = 0;
    int overlapErr = 0, doubleErr = 0, pairErr = 0, intErr = 0;
    logic prevStrobe = 1'b0;
    logic [7:0] txLog[$];
    int strobeCyc[$];

    always #5 clk = ~clk;

    assign txStat = {7'h2A, holdBusy | (uartCnt >= 4)};

    uart_tx_fifo #(.DEPTH_LOG2(4)) dut (
        .i_clk     (clk),
        .i_reset   (iReset),
        .i_cyc     (iCyc),
        .i_we      (iWe),
        .i_dat     (iDat),
        .o_dat     (oDat),
        .o_tx_cyc  (oTxCyc),
        .o_tx_we   (oTxWe),
        .o_tx_dat  (oTxDat),
        .i_tx_stat (txStat),
        .o_int     (oInt)
    );

    always @(posedge clk) cycleNo <= cycleNo + 1;

    // Serializer model: busy rises on the 4th cycle after the strobe, lasts BUSY_LEN cycles.
    always @(negedge clk) begin
        prevStrobe <= (oTxWe === 1'b1);
        if (oTxCyc === 1'b1 || oTxWe === 1'b1) begin
            if (oTxCyc !== oTxWe) pairErr <= pairErr + 1;
            if (prevStrobe) doubleErr <= doubleErr + 1;
            if (uartCnt != 0) overlapErr <= overlapErr + 1;
            txLog.push_back(oTxDat);
            strobeCyc.push_back(cycleNo);
            strobeCount <= strobeCount + 1;
            uartCnt <= 1;
        end else if (uartCnt == BUSY_LEN + 3) begin
            uartCnt <= 0;
        end else if (uartCnt != 0) begin
            uartCnt <= uartCnt + 1;
        end
        if (oInt === 1'b1) begin
            intCount <= intCount + 1;
            if (uartCnt != 0 || holdBusy) intErr <= intErr + 1;
        end
    end

    task automatic pushByte(input logic [7:0] b);
        iCyc = 1'b1; iWe = 1'b1; iDat = b;
        @(negedge clk);
        iCyc = 1'b0; iWe = 1'b0;
    endtask

    task automatic waitIdle(input int limit, input string name);
        int n;
        n = 0;
        while (!(oDat[0] === 1'b0 && uartCnt == 0 && !holdBusy) && n < limit) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        #1;
        assertCount++;
        if (n >= limit) begin
            failCount++;
            $display("[TB] FAIL %s drain timeout: waited %0d cycles, required < %0d", name, n, limit);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        assertCount++;
        if (oDat !== 8'h04) begin failCount++; $display("[TB] FAIL rst_stat: got %h required 04", oDat); end
        assertCount++;
        if (oTxCyc !== 1'b0 || oTxWe !== 1'b0) begin failCount++; $display("[TB] FAIL rst_stb: got %b%b required 00", oTxCyc, oTxWe); end
        assertCount++;
        if (oTxDat !== 8'h00) begin failCount++; $display("[TB] FAIL rst_txdat: got %h required 00", oTxDat); end
        assertCount++;
        if (oInt !== 1'b0) begin failCount++; $display("[TB] FAIL rst_int: got %b required 0", oInt); end
        iReset = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        assertCount++;
        if (oDat !== 8'h04) begin failCount++; $display("[TB] FAIL post_rst_stat: got %h required 04", oDat); end
        assertCount++;
        if (strobeCount !== 0) begin failCount++; $display("[TB] FAIL post_rst_strobes: got %0d required 0", strobeCount); end
    endtask

    task automatic test_latency();
        int i0;
        i0 = intCount;
        txLog.delete();
        pushByte(8'h5A);
        assertCount++;
        if (oTxWe !== 1'b0) begin failCount++; $display("[TB] FAIL lat_early_stb: got %b required 0", oTxWe); end
        assertCount++;
        if (oDat !== 8'h01) begin failCount++; $display("[TB] FAIL lat_stat_queued: got %h required 01", oDat); end
        @(negedge clk);
        assertCount++;
        if (oTxWe !== 1'b1 || oTxCyc !== 1'b1) begin failCount++; $display("[TB] FAIL lat_stb: got %b%b required 11", oTxCyc, oTxWe); end
        assertCount++;
        if (oTxDat !== 8'h5A) begin failCount++; $display("[TB] FAIL lat_txdat: got %h required 5a", oTxDat); end
        assertCount++;
        if (oDat !== 8'h05) begin failCount++; $display("[TB] FAIL lat_stat_issue: got %h required 05", oDat); end
        @(negedge clk);
        assertCount++;
        if (oTxWe !== 1'b0) begin failCount++; $display("[TB] FAIL lat_stb_width: got %b required 0", oTxWe); end
        waitIdle(200, "lat");
        assertCount++;
        if (txLog.size() !== 1 || txLog[0] !== 8'h5A) begin failCount++; $display("[TB] FAIL lat_log: got %0d bytes first %h required 1 byte 5a", txLog.size(), txLog[0]); end
        assertCount++;
        if (intCount - i0 !== 1) begin failCount++; $display("[TB] FAIL lat_int: got %0d pulses required 1", intCount - i0); end
    endtask

    task automatic test_three_bytes();
        logic [7:0] exp [3];
        int i0;
        exp = '{8'h55, 8'hA3, 8'h0D};
        i0 = intCount;
        txLog.delete();
        strobeCyc.delete();
        pushByte(8'h55);
        pushByte(8'hA3);
        pushByte(8'h0D);
        waitIdle(300, "three");
        assertCount++;
        if (txLog.size() !== 3) begin failCount++; $display("[TB] FAIL three_count: got %0d required 3", txLog.size()); end
        for (int i = 0; i < 3 && i < txLog.size(); i++) begin
            assertCount++;
            if (txLog[i] !== exp[i]) begin failCount++; $display("[TB] FAIL three_byte%0d: got %h required %h", i, txLog[i], exp[i]); end
        end
        for (int i = 1; i < 3 && i < strobeCyc.size(); i++) begin
            assertCount++;
            if (strobeCyc[i] - strobeCyc[i-1] !== 15) begin failCount++; $display("[TB] FAIL three_gap%0d: got %0d cycles required 15", i, strobeCyc[i] - strobeCyc[i-1]); end
        end
        assertCount++;
        if (intCount - i0 !== 1) begin failCount++; $display("[TB] FAIL three_int: got %0d pulses required 1", intCount - i0); end
    endtask

    task automatic test_overflow();
        logic [7:0] stat, exp;
        int i0;
        i0 = intCount;
        txLog.delete();
        holdBusy = 1'b1;
        pushByte(8'hEE);
        repeat (6) @(negedge clk);
        for (int i = 0; i < 17; i++) pushByte(8'h10 + 8'(i));
        assertCount++;
        if (oDat !== FULL_OVF_STAT) begin failCount++; $display("[TB] FAIL ovf_stat: got %h required %h", oDat, FULL_OVF_STAT); end
        iCyc = 1'b1; iWe = 1'b0;
        #1 stat = oDat;
        @(negedge clk);
        iCyc = 1'b0;
        assertCount++;
        if (stat !== FULL_OVF_STAT) begin failCount++; $display("[TB] FAIL ovf_read: got %h required %h", stat, FULL_OVF_STAT); end
        assertCount++;
        if (oDat !== 8'h03) begin failCount++; $display("[TB] FAIL ovf_clear: got %h required 03", oDat); end
        holdBusy = 1'b0;
        waitIdle(1000, "ovf");
        assertCount++;
        if (txLog.size() !== 17) begin failCount++; $display("[TB] FAIL ovf_count: got %0d required 17", txLog.size()); end
        for (int i = 0; i < 17 && i < txLog.size(); i++) begin
            exp = (i == 0) ? 8'hEE : 8'h10 + 8'(i - 1);
            assertCount++;
            if (txLog[i] !== exp) begin failCount++; $display("[TB] FAIL ovf_byte%0d: got %h required %h", i, txLog[i], exp); end
        end
        assertCount++;
        if (intCount - i0 !== 1) begin failCount++; $display("[TB] FAIL ovf_int: got %0d pulses required 1", intCount - i0); end
    endtask

    task automatic test_push_pop_same();
        logic [7:0] exp [3];
        int i0;
        exp = '{8'hC1, 8'hC2, 8'hC3};
        i0 = intCount;
        txLog.delete();
        holdBusy = 1'b1;
        pushByte(8'hC1);
        repeat (20) @(negedge clk);
        pushByte(8'hC2);
        holdBusy = 1'b0;
        @(negedge clk);
        pushByte(8'hC3);
        assertCount++;
        if (dut.fifoCount !== 5'd1) begin failCount++; $display("[TB] FAIL pp_count: got %0d required 1", dut.fifoCount); end
        assertCount++;
        if (oTxWe !== 1'b1 || oTxDat !== 8'hC2) begin failCount++; $display("[TB] FAIL pp_issue: got we=%b dat=%h required we=1 dat=c2", oTxWe, oTxDat); end
        waitIdle(300, "pp");
        assertCount++;
        if (txLog.size() !== 3) begin failCount++; $display("[TB] FAIL pp_log_count: got %0d required 3", txLog.size()); end
        for (int i = 0; i < 3 && i < txLog.size(); i++) begin
            assertCount++;
            if (txLog[i] !== exp[i]) begin failCount++; $display("[TB] FAIL pp_byte%0d: got %h required %h", i, txLog[i], exp[i]); end
        end
        assertCount++;
        if (intCount - i0 !== 1) begin failCount++; $display("[TB] FAIL pp_int: got %0d pulses required 1", intCount - i0); end
    endtask

    task automatic test_wrap();
        logic [7:0] exp;
        for (int r = 0; r < 2; r++) begin
            txLog.delete();
            holdBusy = 1'b1;
            pushByte(8'hF0 + 8'(r));
            repeat (6) @(negedge clk);
            for (int i = 0; i < 16; i++) pushByte(8'h40 + 8'(16 * r + i));
            assertCount++;
            if (oDat !== 8'h03) begin failCount++; $display("[TB] FAIL wrap%0d_full: got %h required 03", r, oDat); end
            holdBusy = 1'b0;
            waitIdle(1000, "wrap");
            assertCount++;
            if (txLog.size() !== 17) begin failCount++; $display("[TB] FAIL wrap%0d_count: got %0d required 17", r, txLog.size()); end
            for (int i = 0; i < 17 && i < txLog.size(); i++) begin
                exp = (i == 0) ? 8'hF0 + 8'(r) : 8'h40 + 8'(16 * r + i - 1);
                assertCount++;
                if (txLog[i] !== exp) begin failCount++; $display("[TB] FAIL wrap%0d_byte%0d: got %h required %h", r, i, txLog[i], exp); end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int s0, i0;
        holdBusy = 1'b1;
        pushByte(8'hAA);
        repeat (6) @(negedge clk);
        for (int i = 0; i < 5; i++) pushByte(8'h60 + 8'(i));
        #1;
        s0 = strobeCount;
        i0 = intCount;
        iReset = 1'b1;
        @(negedge clk);
        assertCount++;
        if (oDat !== 8'h04) begin failCount++; $display("[TB] FAIL mid_rst_stat: got %h required 04", oDat); end
        assertCount++;
        if (oTxWe !== 1'b0 || oTxCyc !== 1'b0 || oTxDat !== 8'h00 || oInt !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL mid_rst_outs: got cyc=%b we=%b dat=%h int=%b required all 0", oTxCyc, oTxWe, oTxDat, oInt);
        end
        iReset = 1'b0;
        holdBusy = 1'b0;
        repeat (100) @(negedge clk);
        #1;
        assertCount++;
        if (strobeCount !== s0) begin failCount++; $display("[TB] FAIL mid_rst_strobes: got %0d required %0d", strobeCount, s0); end
        assertCount++;
        if (intCount !== i0) begin failCount++; $display("[TB] FAIL mid_rst_int: got %0d required %0d", intCount, i0); end
        assertCount++;
        if (oDat !== 8'h04) begin failCount++; $display("[TB] FAIL mid_rst_after: got %h required 04", oDat); end
    endtask

    task automatic test_protocol();
        assertCount++;
        if (overlapErr !== 0) begin failCount++; $display("[TB] FAIL proto_overlap: got %0d required 0", overlapErr); end
        assertCount++;
        if (doubleErr !== 0) begin failCount++; $display("[TB] FAIL proto_stb_width: got %0d required 0", doubleErr); end
        assertCount++;
        if (pairErr !== 0) begin failCount++; $display("[TB] FAIL proto_cyc_we: got %0d required 0", pairErr); end
        assertCount++;
        if (intErr !== 0) begin failCount++; $display("[TB] FAIL proto_int_early: got %0d required 0", intErr); end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time exhausted");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        iReset = 1'b1; iCyc = 1'b0; iWe = 1'b0; iDat = 8'h00; holdBusy = 1'b0;
        test_reset();
        test_latency();
        test_three_bytes();
        test_overflow();
        test_push_pop_same();
        test_wrap();
        test_reset_mid_frame();
        test_protocol();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
